button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Conditions raw board inputs (BTNU/BTND/BTNL/BTNR, SW[1:0]) before they reach game's i_* ports.
//  Per bit: 2-FF synchronizer, then a debounce counter. Outputs the debounced level and 1-cycle press/release pulses.
//  Sits between FPGA top-level pins and game, in the game clock domain (25.175 MHz VGA clock).
// PARAMETERS
//  N_INPUTS        6       number of independent inputs conditioned
//  DEBOUNCE_CYCLES 251750  consecutive stable cycles needed to accept a change (10 ms @ 25.175 MHz); >= 1
//  REPEAT_DELAY    6293750 held cycles before the first auto-repeat pulse (250 ms); used only with macro
//  REPEAT_PERIOD   2517500 cycles between later auto-repeat pulses (100 ms); used only with macro
// PORTS
//  clk        in   1         game clock; all logic on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  i_raw      in   N_INPUTS  raw asynchronous inputs, active high
//  o_level    out  N_INPUTS  debounced level, active high
//  o_press    out  N_INPUTS  1-cycle pulse when a bit's debounced level rises (and on auto-repeat)
//  o_release  out  N_INPUTS  1-cycle pulse when a bit's debounced level falls
// BEHAVIOUR
//  - Clock/reset: one clock, clk. rst_n is asynchronous and active-low.
//  - Reset: sync FFs, counters, o_level, o_press and o_release all clear to 0; counters also held at 0 while reset is asserted.
//    Reset asserted mid-debounce discards progress on every bit.
//  - Counter width: CNT_W = $clog2(DEBOUNCE_CYCLES+1). Counter never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
//  - Bits are fully independent. Any mix of simultaneous changes produces independent pulses in the same cycle.
//  - Synchronizer: sync1 <= i_raw; sync2 <= sync1. Only sync2 is used downstream.
//  - Per-bit debounce, evaluated each edge:
//      sync2 == level                     -> cnt <= 0
//      sync2 != level, cnt <  D-1         -> cnt <= cnt+1
//      sync2 != level, cnt == D-1         -> level <= sync2; cnt <= 0; pulse press (rise) or release (fall)
//  - Latency: define edge 0 as the edge that first samples the new raw value into sync1.
//    If the value stays stable, o_level changes at edge D+1 and the matching pulse is high for exactly that following cycle.
//    With D = 1, the change lands at edge 2.
//  - Glitches: a change reverting before D stable sync2 cycles resets cnt; level and pulses are unaffected.
//  - Inputs already high at reset release: a press is reported D+1 edges after the first post-reset edge (intended: game sees held buttons).
//  - o_press and o_release are never both high on one bit in the same cycle.
//  - Outputs are registered; no combinational path from i_raw to any output.
// CONFIGURATION
//  - Macro BUTTON_DEBOUNCE_REPEAT_EN, when defined:
//    - Each bit gets a repeat counter, counting while o_level is 1.
//    - Extra o_press pulses fire REPEAT_DELAY cycles after the rising-edge pulse, then every REPEAT_PERIOD cycles while held.
//    - The counter clears when o_level falls or on reset. Repeat pulses obey the same one-cycle rule.
//  - Macro not defined: no repeat logic or counters are synthesised; o_press fires only on debounced rising edges.
// TESTING
//  Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_INPUTS=6.
//  1. i_raw[0] 0->1 at edge 0, held
//     -> o_level[0]=1 and o_press[0]=1 from edge 5, for one cycle only; other bits stay 0.
//  2. i_raw[1] high for 3 cycles, then low
//     -> o_level[1], o_press[1] and o_release[1] stay 0 throughout.
//  3. i_raw[2] bounces 1,0,1,1,1,1,1
//     -> exactly one o_press[2], landing 4 stable sync2 cycles after the last bounce; no o_release.
//  4. i_raw[3] held high, then dropped to 0
//     -> o_release[3] pulses once, 5 edges after the drop; o_level[3] returns to 0.
//  5. i_raw[4] high, rst_n pulsed low at cnt=2
//     -> all outputs 0 asynchronously; after release, o_press[4] fires 5 edges after the first post-reset edge.
//  6. (REPEAT_EN) i_raw[5] held high
//     -> o_press[5] at edge 5, 15, 18, 21 ...; with macro undefined, only at edge 5.

Source files
------------

// File: rtl/button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : Per-bit 2-FF synchronizer and debounce counter producing the
//               debounced level plus one-cycle press/release pulses.
//               Optional auto-repeat of press pulses: BUTTON_DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int N_INPUTS        = 6,
  parameter int DEBOUNCE_CYCLES = 251750,
  parameter int REPEAT_DELAY    = 6293750,
  parameter int REPEAT_PERIOD   = 2517500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] i_raw,
  output logic [N_INPUTS-1:0] o_level,
  output logic [N_INPUTS-1:0] o_press,
  output logic [N_INPUTS-1:0] o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0] sync1;
  logic [N_INPUTS-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             release_p;
    logic             settle;
    logic             repeat_fire;

    // settle marks the edge on which a stable new value is accepted
    assign settle = (sync2[i] != level) && (cnt == CNT_LAST);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_phase;

    // A falling settle wins over a repeat so press and release never coincide
    assign repeat_fire = level && !settle &&
                         (rpt_cnt == (rpt_phase ? RPT_NEXT : RPT_FIRST));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (!level || settle) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (repeat_fire) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt   <= rpt_cnt + RPT_W'(1);
      end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= repeat_fire;
        release_p <= 1'b0;
        if (sync2[i] == level) begin
          cnt <= '0;
        end else if (settle) begin
          cnt       <= '0;
          level     <= sync2[i];
          press     <= sync2[i];
          release_p <= ~sync2[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign o_level[i]   = level;
    assign o_press[i]   = press;
    assign o_release[i] = release_p;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module      : tb_button_debounce
// Description : Directed self-checking bench for button_debounce (D=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

  localparam int N = 6;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] rel;

  int checks;
  int errors;
  int press_cnt [N];
  int rel_cnt   [N];

  button_debounce #(
    .N_INPUTS        (N),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw     (raw),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One active edge, then sample on the falling edge and tally pulses
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      press_cnt[i] += int'(press[i]);
      rel_cnt[i]   += int'(rel[i]);
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  initial begin
    logic [6:0] bounce;
    logic       exp_p;
    checks = 0;
    errors = 0;
    clear_counts();
    rst_n = 1'b0;
    raw   = '0;
    steps(3);
    check("reset_level", 32'(level), 32'h0);
    check("reset_press", 32'(press), 32'h0);
    check("reset_release", 32'(rel), 32'h0);
    rst_n = 1'b1;
    steps(2);

    // Clean press on bit 0: level rises at edge 5
    raw[0] = 1'b1;
    steps(5);
    check("t1_level_e4", 32'(level), 32'h00);
    step();
    check("t1_level_e5", 32'(level), 32'h01);
    check("t1_press_e5", 32'(press), 32'h01);
    check("t1_release_e5", 32'(rel), 32'h00);
    step();
    check("t1_press_e6", 32'(press), 32'h00);
    check("t1_level_e6", 32'(level), 32'h01);

    // Three-cycle pulse on bit 1 is one cycle short of acceptance
    clear_counts();
    raw[1] = 1'b1;
    steps(3);
    raw[1] = 1'b0;
    steps(8);
    check("t2_press_cnt", 32'(press_cnt[1]), 32'd0);
    check("t2_release_cnt", 32'(rel_cnt[1]), 32'd0);
    check("t2_level", 32'(level), 32'h01);

    // Bounce 1,0,1,1,1,1,1 on bit 2: accepted at edge 7
    clear_counts();
    bounce = 7'b1111101;
    for (int k = 0; k < 7; k++) begin
      raw[2] = bounce[k];
      step();
    end
    check("t3_level_e6", 32'(level[2]), 32'd0);
    step();
    check("t3_level_e7", 32'(level[2]), 32'd1);
    check("t3_press_e7", 32'(press[2]), 32'd1);
    steps(4);
    check("t3_press_cnt", 32'(press_cnt[2]), 32'd1);
    check("t3_release_cnt", 32'(rel_cnt[2]), 32'd0);

    // Hold then drop bit 3: release 5 edges after the drop
    clear_counts();
    raw[3] = 1'b1;
    steps(10);
    check("t4_level_held", 32'(level[3]), 32'd1);
    raw[3] = 1'b0;
    steps(5);
    check("t4_release_e4", 32'(rel), 32'h00);
    check("t4_level_e4", 32'(level[3]), 32'd1);
    step();
    check("t4_release_e5", 32'(rel), 32'h08);
    check("t4_level_e5", 32'(level[3]), 32'd0);
    check("t4_press_e5", 32'(press[3]), 32'd0);
    step();
    check("t4_release_e6", 32'(rel), 32'h00);
    check("t4_press_cnt", 32'(press_cnt[3]), 32'd1);
    check("t4_release_cnt", 32'(rel_cnt[3]), 32'd1);

    // Async reset mid-debounce on bit 4; held bits re-report after release
    raw[4] = 1'b1;
    steps(4);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(level), 32'h00);
    check("t5_async_press", 32'(press), 32'h00);
    check("t5_async_release", 32'(rel), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    steps(5);
    check("t5_press_e4", 32'(press), 32'h00);
    check("t5_level_e4", 32'(level), 32'h00);
    step();
    check("t5_press_e5", 32'(press), 32'h15);
    check("t5_level_e5", 32'(level), 32'h15);

    // Bit 5 held: press at edge 5, repeats at 15, 18, 21 when enabled
    raw[5] = 1'b1;
    for (int e = 0; e < 23; e++) begin
      step();
      exp_p = (e == 5);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      exp_p = exp_p || (e == 15) || (e == 18) || (e == 21);
`endif
      check($sformatf("t6_press5_e%0d", e), 32'(press[5]), 32'(exp_p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
